// File: rtl/usb_txpkt_framer.sv
`default_nettype none
// ============================================================================
// usb_txpkt_framer : frames PID / payload / CRC16 bytes toward the bit-level TX.
// Optional payload clamp when USB_TXPKT_CLAMP_EN is defined.
// Revision 1.0
// ============================================================================
module usb_txpkt_framer #(
    parameter int unsigned MAX_LEN = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txpkt_start,
    input  logic [3:0] txpkt_pid,
    input  logic [9:0] txpkt_len,
    input  logic [7:0] txpkt_data,
    output logic       txpkt_data_ack,
    output logic       txpkt_done,
    output logic [7:0] phy_data,
    output logic       phy_valid,
    output logic       phy_last,
    input  logic       phy_ready,
    input  logic       phy_eop_done,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PID    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;
    localparam logic [2:0] S_EOP    = 3'd5;

    logic [2:0]  state_q,  state_d;
    logic        data_pkt_q, data_pkt_d;
    logic [9:0]  rem_q,    rem_d;
    logic [15:0] crc_q,    crc_d;
    logic        fetch_q,  fetch_d;
    logic        ack_dly_q, ack_dly_d;
    logic [7:0]  pdata_q,  pdata_d;
    logic        pvalid_q, pvalid_d;
    logic        plast_q,  plast_d;
    logic        done_q,   done_d;

    logic [9:0]  len_eff;
    logic        accept;
    logic        out_free;
    logic        load_byte;

`ifdef USB_TXPKT_CLAMP_EN
    localparam logic [9:0] LEN_CAP = 10'(MAX_LEN);
    assign len_eff = (txpkt_len > LEN_CAP) ? LEN_CAP : txpkt_len;
`else
    assign len_eff = txpkt_len;
`endif

    // Reflected CRC16 (0xA001), data bits consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign accept    = pvalid_q & phy_ready;
    assign out_free  = ~pvalid_q | accept;
    assign load_byte = (state_q == S_DATA) & fetch_q & out_free & (rem_q != 10'd0);

    always_comb begin
        state_d    = state_q;
        data_pkt_d = data_pkt_q;
        rem_d      = rem_q;
        crc_d      = crc_q;
        fetch_d    = ack_dly_q ? 1'b1 : fetch_q;
        ack_dly_d  = 1'b0;
        pdata_d    = pdata_q;
        pvalid_d   = pvalid_q;
        plast_d    = plast_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle still reads as idle, so a coincident start is dropped.
                if (txpkt_start && !done_q) begin
                    data_pkt_d = (txpkt_pid[1:0] == 2'b11);
                    rem_d      = len_eff;
                    crc_d      = 16'hFFFF;
                    fetch_d    = 1'b1;
                    pdata_d    = {~txpkt_pid, txpkt_pid};
                    pvalid_d   = 1'b1;
                    plast_d    = (txpkt_pid[1:0] != 2'b11);
                    state_d    = S_PID;
                end
            end
            S_PID: begin
                if (accept) begin
                    if (!data_pkt_q) begin
                        pvalid_d = 1'b0;
                        plast_d  = 1'b0;
                        state_d  = S_EOP;
                    end else if (rem_q == 10'd0) begin
                        pdata_d = ~crc_q[7:0];
                        plast_d = 1'b0;
                        state_d = S_CRC_LO;
                    end else begin
                        pvalid_d = 1'b0;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && rem_q == 10'd0) begin
                    pdata_d = ~crc_q[7:0];
                    plast_d = 1'b0;
                    state_d = S_CRC_LO;
                end else if (load_byte) begin
                    pdata_d   = txpkt_data;
                    pvalid_d  = 1'b1;
                    plast_d   = 1'b0;
                    crc_d     = crc16_byte(crc_q, txpkt_data);
                    rem_d     = rem_q - 10'd1;
                    fetch_d   = 1'b0;
                    ack_dly_d = 1'b1;
                end else if (accept) begin
                    pvalid_d = 1'b0;
                end
            end
            S_CRC_LO: begin
                if (accept) begin
                    pdata_d = ~crc_q[15:8];
                    plast_d = 1'b1;
                    state_d = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (accept) begin
                    pvalid_d = 1'b0;
                    plast_d  = 1'b0;
                    state_d  = S_EOP;
                end
            end
            S_EOP: begin
                if (phy_eop_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                pvalid_d = 1'b0;
                plast_d  = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_pkt_q <= 1'b0;
            rem_q      <= 10'd0;
            crc_q      <= 16'hFFFF;
            fetch_q    <= 1'b0;
            ack_dly_q  <= 1'b0;
            pdata_q    <= 8'd0;
            pvalid_q   <= 1'b0;
            plast_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_pkt_q <= data_pkt_d;
            rem_q      <= rem_d;
            crc_q      <= crc_d;
            fetch_q    <= fetch_d;
            ack_dly_q  <= ack_dly_d;
            pdata_q    <= pdata_d;
            pvalid_q   <= pvalid_d;
            plast_q    <= plast_d;
            done_q     <= done_d;
        end
    end

    assign txpkt_data_ack = load_byte;
    assign txpkt_done     = done_q;
    assign phy_data       = pdata_q;
    assign phy_valid      = pvalid_q;
    assign phy_last       = plast_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
